// File: rtl/sort_seq_pkg.sv
// Shared types and helpers for the sequence-compare framing logic.
package sort_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_e;

  localparam int FRAME_IDX_W = 8;
  localparam int MAX_W       = 32;

  // Callers zero-extend narrower operands to MAX_W and size-cast the result back.
  function automatic logic [MAX_W-1:0] max_u(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sort_frame_controller_if.sv
// Sample-in / result-out handshake bundle of the frame controller.
interface sort_frame_controller_if #(
  parameter int DW = 3
);
  import sort_seq_pkg::*;

  logic [DW-1:0]          in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [DW-1:0]          out_max;
  logic [FRAME_IDX_W-1:0] out_frame;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_max, out_frame, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_max, out_frame, out_valid
  );

endinterface

// File: rtl/seq_max_accum.sv
// Running unsigned-maximum register; load restarts it, en folds in a new sample.
module seq_max_accum
  import sort_seq_pkg::*;
#(
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= DW'(max_u(MAX_W'(q), MAX_W'(d)));
    end
  end

endmodule

// File: rtl/sort_frame_controller.sv
// Cuts a handshaked sample stream into FRAME_LEN-sample frames and reports each frame maximum.
module sort_frame_controller
  import sort_seq_pkg::*;
#(
  parameter int DW        = 3,
  parameter int FRAME_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  sort_frame_controller_if.slave io
);

  localparam int              IDX_W    = $clog2(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e                 state, state_nx;
  logic [IDX_W-1:0]       idx, idx_nx;
  logic [DW-1:0]          acc, acc_d, frame_max;
  logic [DW-1:0]          out_max_q;
  logic [FRAME_IDX_W-1:0] out_frame_q;
  logic                   out_valid_q;
  logic                   acc_load, acc_en, set_out;
  logic                   beat, take;

  assign io.in_ready  = rst_n && !flush && (state != HOLD);
  assign io.out_max   = out_max_q;
  assign io.out_frame = out_frame_q;
  assign io.out_valid = out_valid_q;

  assign beat = io.in_valid && io.in_ready;
  assign take = out_valid_q && io.out_ready;

  // A frame can only complete from IDLE when it is a single sample long.
  assign frame_max = (state == IDLE) ? io.in_data
                                     : DW'(max_u(MAX_W'(acc), MAX_W'(io.in_data)));

  seq_max_accum #(.DW(DW)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (acc_load),
    .en    (acc_en),
    .d     (acc_d),
    .q     (acc)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_nx = state;
    idx_nx   = idx;
    acc_load = 1'b0;
    acc_en   = 1'b0;
    acc_d    = io.in_data;
    set_out  = 1'b0;

    unique case (state)
      IDLE, ACCUM: begin
        if (flush) begin
          // Loading zero is how the partial maximum is discarded.
          state_nx = IDLE;
          idx_nx   = '0;
          acc_load = 1'b1;
          acc_d    = '0;
        end else if (beat && state == IDLE) begin
          acc_load = 1'b1;
          idx_nx   = IDX_W'(1);
          if (FRAME_LEN == 1) begin
            set_out  = 1'b1;
            state_nx = HOLD;
          end else begin
            state_nx = ACCUM;
          end
        end else if (beat) begin
          acc_en = 1'b1;
          idx_nx = idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            set_out  = 1'b1;
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        if (take) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_frame_q <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (set_out) begin
        out_valid_q <= 1'b1;
        out_max_q   <= frame_max;
      end else if (take) begin
        out_valid_q <= 1'b0;
        out_frame_q <= out_frame_q + FRAME_IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sort_frame_controller.sv
// Scoreboard bench: a frame-level predictor queues expected results, a monitor checks the DUT each cycle.
module tb_sort_frame_controller;

  localparam int DW        = 3;
  localparam int FRAME_LEN = 4;

  typedef struct {
    logic [DW-1:0] mx;
    logic [7:0]    fr;
  } result_t;

  logic clk;
  logic rst_n;
  logic flush;

  sort_frame_controller_if #(.DW(DW)) io ();

  sort_frame_controller #(.DW(DW), .FRAME_LEN(FRAME_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_takes  = 0;
  int wrap_seen = 0;
  int saw255    = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [DW-1:0] m_samp[$];
  result_t       exp_q[$];
  int            m_hold  = 0;
  logic [DW-1:0] m_max   = '0;
  logic [7:0]    m_frame = '0;

  int            cur_ready, cur_valid;
  logic [DW-1:0] cur_max;
  logic [7:0]    cur_frame;

  // Predictor: looks at the inputs the coming edge will see and advances the model.
  always begin
    @(negedge clk);
    #1;
    cur_ready = int'(rst_n && !flush && m_hold == 0);
    cur_valid = m_hold;
    cur_max   = m_max;
    cur_frame = m_frame;
    if (!rst_n) begin
      m_samp.delete();
      exp_q.delete();
      m_hold  = 0;
      m_max   = '0;
      m_frame = '0;
    end else if (m_hold != 0) begin
      if (io.out_ready) begin
        m_hold  = 0;
        m_frame = m_frame + 8'd1;
      end
    end else if (flush) begin
      m_samp.delete();
    end else if (io.in_valid) begin
      m_samp.push_back(io.in_data);
      if (m_samp.size() == FRAME_LEN) begin
        logic [DW-1:0] mx;
        mx = '0;
        foreach (m_samp[i]) if (m_samp[i] > mx) mx = m_samp[i];
        exp_q.push_back('{mx: mx, fr: m_frame});
        m_max  = mx;
        m_hold = 1;
        m_samp.delete();
      end
    end
  end

  // Monitor: compares outputs every cycle and pops the scoreboard on each take.
  always begin
    result_t e;
    @(negedge clk);
    #3;
    check("in_ready",  int'(io.in_ready),  cur_ready);
    check("out_valid", int'(io.out_valid), cur_valid);
    check("out_max",   int'(io.out_max),   int'(cur_max));
    check("out_frame", int'(io.out_frame), int'(cur_frame));
    if (rst_n && io.out_valid && io.out_ready) begin
      check("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_max",   int'(io.out_max),   int'(e.mx));
        check("sb_frame", int'(io.out_frame), int'(e.fr));
        if (saw255 != 0 && io.out_frame == 8'd0) wrap_seen = 1;
        saw255 = int'(io.out_frame == 8'd255);
        n_takes++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [DW-1:0] d);
    int waited = 0;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_data  = d;
    flush       = 1'b0;
    #2;
    while (!io.in_ready && waited < 100) begin
      @(negedge clk);
      #2;
      waited++;
    end
    check("send_timeout", int'(waited < 100), 1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      io.in_valid = 1'b0;
      flush       = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n       = 1'b0;
    io.in_valid = 1'b0;
    flush       = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_list(input logic [DW-1:0] a, b, c, d);
    send(a); send(b); send(c); send(d);
  endtask

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: descending frame, result handed straight over
    send_list(3'd7, 3'd6, 3'd5, 3'd4);
    idle(4);

    // 2: output stalled for 10+ cycles, second frame waits behind the first
    do_reset(1);
    fork
      begin
        send_list(3'd2, 3'd5, 3'd1, 3'd3);
        send_list(3'd0, 3'd0, 3'd6, 3'd6);
      end
      begin
        io.out_ready = 1'b0;
        repeat (14) @(negedge clk);
        io.out_ready = 1'b1;
      end
    join
    idle(4);

    // 3: flush with a coincident sample drops the partial frame and the sample
    do_reset(1);
    send(3'd3);
    send(3'd7);
    @(negedge clk);
    flush       = 1'b1;
    io.in_valid = 1'b1;
    io.in_data  = 3'd1;
    send_list(3'd4, 3'd4, 3'd4, 3'd4);
    idle(4);

    // 4: flush during HOLD leaves the held result intact
    do_reset(1);
    io.out_ready = 1'b0;
    send_list(3'd6, 3'd3, 3'd6, 3'd1);
    repeat (3) begin
      @(negedge clk);
      flush       = 1'b1;
      io.in_valid = 1'b1;
      io.in_data  = 3'd7;
    end
    idle(3);
    io.out_ready = 1'b1;
    idle(3);

    // 5: 257 frames so the frame index wraps 255 -> 0
    do_reset(1);
    for (int f = 0; f < 257; f++) begin
      for (int s = 0; s < FRAME_LEN; s++) send(3'($urandom));
    end
    idle(4);

    // 6: reset mid-frame, no stale maximum afterwards
    do_reset(1);
    send(3'd7);
    send(3'd5);
    do_reset(1);
    send_list(3'd1, 3'd1, 3'd1, 3'd2);
    idle(4);

    // random traffic with flushes, stalls and the occasional reset
    repeat (2000) begin
      @(negedge clk);
      rst_n        = ($urandom_range(0, 299) != 0);
      io.in_valid  = ($urandom_range(0, 3) != 0);
      io.in_data   = 3'($urandom);
      flush        = ($urandom_range(0, 15) == 0);
      io.out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    rst_n        = 1'b1;
    io.out_ready = 1'b1;
    idle(12);
    #5;

    check("sb_empty",  exp_q.size(), 0);
    check("wrap_seen", wrap_seen, 1);
    check("min_takes", int'(n_takes >= 263), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
